// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RISC-V datapath: sequences fetch, decode,
// execute, memory and writeback, and decodes every datapath select and enable.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       neg,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic [3:0] state,
    output logic       illegal
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    state_t cur_state, next_state;
    logic   illegal_q;
    logic   pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    // Branch compares use the ALU flags; neg is not needed for the supported set.
    logic unused_neg;
    assign unused_neg = neg;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (next_state == S_ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        next_state  = S_FETCH;
        pc_write_c  = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 3'b000;

        case (cur_state)
            S_FETCH: begin
                ir_write_c = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write_c = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_B:    imm_src = 3'b010;
                    OP_JAL:  imm_src = 3'b100;
                    OP_SW:   imm_src = 3'b001;
                    OP_LUI:  imm_src = 3'b011;
                    default: imm_src = 3'b000;
                endcase
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXEC_R;
                    OP_I:         next_state = S_EXEC_I;
                    OP_B:         next_state = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101})
                                               ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:       next_state = S_JAL;
                    OP_JALR:      next_state = S_JALR;
                    OP_LUI:       next_state = S_LUI;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = (opcode == OP_SW) ? 3'b001 : 3'b000;
                next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7_5);
                next_state  = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, 1'b0);
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
                case (funct3)
                    3'b000:  pc_write_c = zero;
                    3'b001:  pc_write_c = !zero;
                    3'b100:  pc_write_c = !zero;
                    3'b101:  pc_write_c = zero;
                    default: pc_write_c = 1'b0;
                endcase
            end
            S_JAL, S_JALR2: begin
                pc_write_c = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = S_JALR2;
            end
            S_LUI: begin
                imm_src     = 3'b011;
                result_src  = 2'b11;
                reg_write_c = 1'b1;
            end
            S_ILLEGAL: begin
                next_state = S_ILLEGAL;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Architectural writes are suppressed while reset is held.
    assign pc_write  = pc_write_c  & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign state     = cur_state;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: walks each instruction
// class through its state sequence and checks the key controls per state.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       neg;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic [3:0] state;

    int checks = 0;
    int passed = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .neg(neg),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .reg_write(reg_write), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] en;
        rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        zero = 1'b0; neg = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            en = {pc_write, ir_write, mem_write, reg_write};
            checks++;
            if (en !== 4'b0000) $display("FAIL reset_enables[%0d]: got %b want 0000", i, en);
            else passed++;
        end
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0)
            $display("FAIL reset_state: got state=%0d illegal=%b want 0/0", state, illegal);
        else passed++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1)
            $display("FAIL reset_release: got state=%0d ir=%b pc=%b want 0/1/1", state, ir_write, pc_write);
        else passed++;
    endtask

    task automatic test_r_sub();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_st[i]) $display("FAIL sub_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            else passed++;
            if (i < 4) begin
                checks++;
                if (reg_write !== (exp_st[i] == 4'd8))
                    $display("FAIL sub_reg_write[%0d]: got %b want %b", i, reg_write, exp_st[i] == 4'd8);
                else passed++;
            end
            if (exp_st[i] == 4'd6) begin
                checks++;
                if (alu_control !== 3'b001) $display("FAIL sub_alu: got %b want 001", alu_control);
                else passed++;
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_addi_no_sub();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd7, 4'd8};
        opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== exp_st[i]) $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            else passed++;
            if (exp_st[i] == 4'd7) begin
                checks++;
                if (alu_control !== 3'b000 || alu_src_b !== 2'b01 || imm_src !== 3'b000)
                    $display("FAIL addi_ctrl: got alu=%b b=%b imm=%b want 000/01/000", alu_control, alu_src_b, imm_src);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_lw_sw();
        logic [3:0] lw_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [3:0] sw_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== lw_st[i]) $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, lw_st[i]);
            else passed++;
            if (lw_st[i] == 4'd2) begin
                checks++;
                if (imm_src !== 3'b000) $display("FAIL lw_imm: got %b want 000", imm_src);
                else passed++;
            end
            if (lw_st[i] == 4'd4) begin
                checks++;
                if (result_src !== 2'b01 || reg_write !== 1'b1)
                    $display("FAIL lw_wb: got res=%b rw=%b want 01/1", result_src, reg_write);
                else passed++;
            end
            tick();
        end
        opcode = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== sw_st[i]) $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, sw_st[i]);
            else passed++;
            if (sw_st[i] == 4'd1 || sw_st[i] == 4'd2) begin
                checks++;
                if (imm_src !== 3'b001) $display("FAIL sw_imm[%0d]: got %b want 001", i, imm_src);
                else passed++;
            end
            if (sw_st[i] == 4'd5) begin
                checks++;
                if (mem_write !== 1'b1 || adr_src !== 1'b1 || reg_write !== 1'b0)
                    $display("FAIL sw_write: got mw=%b adr=%b rw=%b want 1/1/0", mem_write, adr_src, reg_write);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic z,
                               input logic exp_pc, input logic [2:0] exp_alu);
        opcode = 7'b1100011; funct3 = f3; funct7_5 = 1'b0; zero = z;
        tick();
        checks++;
        if (state !== 4'd1 || imm_src !== 3'b010)
            $display("FAIL br_decode f3=%b: got state=%0d imm=%b want 1/010", f3, state, imm_src);
        else passed++;
        tick();
        checks++;
        if (state !== 4'd9 || pc_write !== exp_pc || alu_control !== exp_alu)
            $display("FAIL br_exec f3=%b z=%b: got state=%0d pc=%b alu=%b want 9/%b/%b",
                     f3, z, state, pc_write, alu_control, exp_pc, exp_alu);
        else passed++;
        zero = !z;
        #1;
        checks++;
        if (pc_write !== !exp_pc)
            $display("FAIL br_comb f3=%b: got pc=%b want %b", f3, pc_write, !exp_pc);
        else passed++;
        tick();
        checks++;
        if (state !== 4'd0) $display("FAIL br_return f3=%b: got %0d want 0", f3, state);
        else passed++;
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [3:0] jal_st [4]  = '{4'd0, 4'd1, 4'd10, 4'd8};
        logic [3:0] jalr_st [5] = '{4'd0, 4'd1, 4'd11, 4'd12, 4'd8};
        opcode = 7'b1101111; funct3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== jal_st[i]) $display("FAIL jal_state[%0d]: got %0d want %0d", i, state, jal_st[i]);
            else passed++;
            if (jal_st[i] == 4'd1) begin
                checks++;
                if (imm_src !== 3'b100) $display("FAIL jal_imm: got %b want 100", imm_src);
                else passed++;
            end
            if (jal_st[i] == 4'd10) begin
                checks++;
                if (pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10)
                    $display("FAIL jal_exec: got pc=%b a=%b b=%b want 1/01/10", pc_write, alu_src_a, alu_src_b);
                else passed++;
            end
            tick();
        end
        opcode = 7'b1100111;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== jalr_st[i]) $display("FAIL jalr_state[%0d]: got %0d want %0d", i, state, jalr_st[i]);
            else passed++;
            if (jalr_st[i] == 4'd12) begin
                checks++;
                if (pc_write !== 1'b1) $display("FAIL jalr2_pc: got %b want 1", pc_write);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_lui();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd13, 4'd0};
        opcode = 7'b0110111;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== exp_st[i]) $display("FAIL lui_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
            else passed++;
            if (exp_st[i] == 4'd13 || exp_st[i] == 4'd1) begin
                checks++;
                if (imm_src !== 3'b011) $display("FAIL lui_imm[%0d]: got %b want 011", i, imm_src);
                else passed++;
            end
            if (exp_st[i] == 4'd13) begin
                checks++;
                if (result_src !== 2'b11 || reg_write !== 1'b1)
                    $display("FAIL lui_wb: got res=%b rw=%b want 11/1", result_src, reg_write);
                else passed++;
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3);
        logic [3:0] en;
        opcode = op; funct3 = f3;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            en = {pc_write, ir_write, mem_write, reg_write};
            checks++;
            if (state !== 4'd14 || illegal !== 1'b1 || en !== 4'b0000)
                $display("FAIL illegal_hold op=%b cyc=%0d: got state=%0d ill=%b en=%b want 14/1/0000",
                         op, i, state, illegal, en);
            else passed++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        en = {pc_write, ir_write, mem_write, reg_write};
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0 || en !== 4'b0000)
            $display("FAIL illegal_reset op=%b: got state=%0d ill=%b en=%b want 0/0/0000", op, state, illegal, en);
        else passed++;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_mid_reset();
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b0 || pc_write !== 1'b0)
            $display("FAIL midrst_force: got rw=%b pc=%b want 0/0", reg_write, pc_write);
        else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) $display("FAIL midrst_state: got %0d want 0", state);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_r_sub();
        test_addi_no_sub();
        test_lw_sw();
        test_branch(3'b001, 1'b1, 1'b0, 3'b001);
        test_branch(3'b001, 1'b0, 1'b1, 3'b001);
        test_branch(3'b100, 1'b0, 1'b1, 3'b100);
        test_branch(3'b000, 1'b1, 1'b1, 3'b001);
        test_branch(3'b101, 1'b0, 1'b0, 3'b100);
        test_jumps();
        test_lui();
        test_illegal(7'b1111111, 3'b000);
        test_illegal(7'b1100011, 3'b010);
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end
endmodule
